// File: rtl/alu16_seq_if.sv
// alu16_seq_if: operand/op drive and result/flag return between the 16-bit sequencer and the shared alu8.
// Sequencer uses the master modport; the alu8 side uses the slave modport.
`default_nettype none

interface alu16_seq_if;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_op7;
  logic       alu_c_in;
  logic [7:0] alu_out;
  logic       alu_c;
  logic       alu_z;
  logic       alu_n;
  logic       alu_v;

  modport master (
    output alu_a, alu_b, alu_op, alu_op7, alu_c_in,
    input  alu_out, alu_c, alu_z, alu_n, alu_v
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_op7, alu_c_in,
    output alu_out, alu_c, alu_z, alu_n, alu_v
  );
endinterface

`default_nettype wire

// File: rtl/alu16_seq.sv
// alu16_seq: runs 16-bit D ops (LDD/ADDD/SUBD/CMPD) as two chained byte passes on the shared alu8.
// Rev 1.0. Define ALU16_SEQ_MUL_EN to build op 4 = 8x8 unsigned MUL (shift-add on alu8).
`default_nettype none

module alu16_seq #(
  parameter int MUL_ITER = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op16,
  input  logic [15:0] opnd_a,
  input  logic [15:0] opnd_b,
  input  logic [3:0]  cc_in,
  output logic        busy,
  output logic        done,
  output logic        wr_en,
  output logic        illegal,
  output logic [15:0] result_q,
  output logic [3:0]  cc_out,
  alu16_seq_if.master alu
);

  localparam logic [2:0] OP_LDD  = 3'd0;
  localparam logic [2:0] OP_ADDD = 3'd1;
  localparam logic [2:0] OP_SUBD = 3'd2;
  localparam logic [2:0] OP_CMPD = 3'd3;

  localparam logic [3:0] ALU_SUB = 4'h0;
  localparam logic [3:0] ALU_CMP = 4'h1;
  localparam logic [3:0] ALU_SBC = 4'h2;
  localparam logic [3:0] ALU_LD  = 4'h6;
  localparam logic [3:0] ALU_ADC = 4'h9;
  localparam logic [3:0] ALU_ADD = 4'hb;
  localparam logic [3:0] ALU_TST = 4'hd;

`ifdef ALU16_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd4;
  typedef enum logic [2:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE, ST_MINIT, ST_MUL} state_t;
  logic [2:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [3:0]  cc_q, cc_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d;
  logic        carry_q, carry_d, zlo_q, zlo_d;
  logic        hn_q, hn_d, hz_q, hz_d, hv_q, hv_d, hc_q, hc_d;
  logic        done_q, done_d, wr_en_q, wr_en_d, illegal_q, illegal_d;
  logic [15:0] result_d;
  logic [3:0]  cc_out_q, cc_out_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cc_d      = cc_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    carry_d   = carry_q;
    zlo_d     = zlo_q;
    hn_d      = hn_q;
    hz_d      = hz_q;
    hv_d      = hv_q;
    hc_d      = hc_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    illegal_d = 1'b0;
    result_d  = result_q;
    cc_out_d  = cc_out_q;
`ifdef ALU16_SEQ_MUL_EN
    cnt_d     = cnt_q;
`endif
    // Idle drive is a tst of zero so the alu8 outputs stay quiet.
    alu.alu_a    = 8'h00;
    alu.alu_b    = 8'h00;
    alu.alu_op   = ALU_TST;
    alu.alu_op7  = 1'b0;
    alu.alu_c_in = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op16;
          a_d  = opnd_a;
          b_d  = opnd_b;
          cc_d = cc_in;
          if (op16 <= OP_CMPD) begin
            state_d = ST_LO;
`ifdef ALU16_SEQ_MUL_EN
          end else if (op16 == OP_MUL) begin
            state_d = ST_MINIT;
`endif
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_LO: begin
        alu.alu_a   = a_q[7:0];
        alu.alu_b   = b_q[7:0];
        alu.alu_op7 = 1'b1;
        case (op_q)
          OP_LDD:  alu.alu_op = ALU_LD;
          OP_ADDD: alu.alu_op = ALU_ADD;
          OP_SUBD: alu.alu_op = ALU_SUB;
          default: alu.alu_op = ALU_CMP;
        endcase
        lo_d    = alu.alu_out;
        carry_d = alu.alu_c;
        zlo_d   = alu.alu_z;
        state_d = ST_HI;
      end

      ST_HI: begin
        alu.alu_a   = a_q[15:8];
        alu.alu_b   = b_q[15:8];
        alu.alu_op7 = 1'b1;
        case (op_q)
          OP_LDD: begin
            alu.alu_op   = ALU_LD;
            alu.alu_c_in = carry_q;
          end
          OP_ADDD: begin
            alu.alu_op   = ALU_ADC;
            alu.alu_c_in = carry_q;
          end
          default: begin
            // alu8 reports raw carry; sbc wants the low-byte borrow.
            alu.alu_op   = ALU_SBC;
            alu.alu_c_in = ~carry_q;
          end
        endcase
        hi_d    = alu.alu_out;
        hn_d    = alu.alu_n;
        hz_d    = alu.alu_z;
        hv_d    = alu.alu_v;
        hc_d    = alu.alu_c;
        state_d = ST_DONE;
      end

`ifdef ALU16_SEQ_MUL_EN
      ST_MINIT: begin
        hi_d    = 8'h00;
        lo_d    = b_q[7:0];
        cnt_d   = 3'd0;
        state_d = ST_MUL;
      end

      ST_MUL: begin
        alu.alu_a = hi_q;
        alu.alu_b = a_q[15:8];
        if (lo_q[0]) begin
          alu.alu_op  = ALU_ADD;
          alu.alu_op7 = 1'b1;
        end
        {hi_d, lo_d} = {alu.alu_c & lo_q[0], alu.alu_out, lo_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(MUL_ITER - 1)) begin
          state_d = ST_DONE;
        end
      end
`endif

      default: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        case (op_q)
          OP_LDD: begin
            wr_en_d  = 1'b1;
            result_d = {hi_q, lo_q};
            cc_out_d = {hn_q, zlo_q & hz_q, 1'b0, cc_q[0]};
          end
          OP_ADDD: begin
            wr_en_d  = 1'b1;
            result_d = {hi_q, lo_q};
            cc_out_d = {hn_q, zlo_q & hz_q, hv_q, hc_q};
          end
          OP_SUBD: begin
            wr_en_d  = 1'b1;
            result_d = {hi_q, lo_q};
            cc_out_d = {hn_q, zlo_q & hz_q, hv_q, ~hc_q};
          end
          OP_CMPD: begin
            cc_out_d = {hn_q, zlo_q & hz_q, hv_q, ~hc_q};
          end
`ifdef ALU16_SEQ_MUL_EN
          OP_MUL: begin
            wr_en_d  = 1'b1;
            result_d = {hi_q, lo_q};
            cc_out_d = {cc_q[3], ({hi_q, lo_q} == 16'h0000), cc_q[1], lo_q[7]};
          end
`endif
          default: begin
            illegal_d = 1'b1;
            cc_out_d  = cc_q;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 3'd0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      cc_q      <= 4'h0;
      lo_q      <= 8'h00;
      hi_q      <= 8'h00;
      carry_q   <= 1'b0;
      zlo_q     <= 1'b0;
      hn_q      <= 1'b0;
      hz_q      <= 1'b0;
      hv_q      <= 1'b0;
      hc_q      <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= 16'h0000;
      cc_out_q  <= 4'h0;
`ifdef ALU16_SEQ_MUL_EN
      cnt_q     <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cc_q      <= cc_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      carry_q   <= carry_d;
      zlo_q     <= zlo_d;
      hn_q      <= hn_d;
      hz_q      <= hz_d;
      hv_q      <= hv_d;
      hc_q      <= hc_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      cc_out_q  <= cc_out_d;
`ifdef ALU16_SEQ_MUL_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign illegal = illegal_q;
  assign cc_out  = cc_out_q;

endmodule

`default_nettype wire

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: alu8 stand-in plus a 16-bit arithmetic reference for alu16_seq; directed and random ops.
// Follows ALU16_SEQ_MUL_EN the same way as the design.
`default_nettype none

module tb_alu16_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] opnd_a = 16'h0000;
  logic [15:0] opnd_b = 16'h0000;
  logic [3:0]  cc_in = 4'h0;
  logic        busy, done, wr_en, illegal;
  logic [15:0] result_q;
  logic [3:0]  cc_out;

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] exp_result = 16'h0000;

  always #5 clock = ~clock;

  alu16_seq_if alu_bus ();

  alu16_seq dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op16     (op16),
    .opnd_a   (opnd_a),
    .opnd_b   (opnd_b),
    .cc_in    (cc_in),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .illegal  (illegal),
    .result_q (result_q),
    .cc_out   (cc_out),
    .alu      (alu_bus)
  );

  // alu8 stand-in: 6809 byte ops, c is raw carry (1 = no borrow on subtract).
  logic [8:0] m_s;
  logic [7:0] m_r;
  logic       m_c, m_v, m_bin;
  always_comb begin
    m_s = 9'd0;
    m_r = 8'd0;
    m_c = 1'b0;
    m_v = 1'b0;
    m_bin = 1'b0;
    case (alu_bus.alu_op)
      4'hb, 4'h9: begin
        m_bin = (alu_bus.alu_op == 4'h9) ? alu_bus.alu_c_in : 1'b0;
        m_s = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b} + {8'd0, m_bin};
        m_r = m_s[7:0];
        m_c = m_s[8];
        m_v = (alu_bus.alu_a[7] == alu_bus.alu_b[7]) && (m_r[7] != alu_bus.alu_a[7]);
      end
      4'h0, 4'h1, 4'h2: begin
        m_bin = (alu_bus.alu_op == 4'h2) ? alu_bus.alu_c_in : 1'b0;
        m_s = {1'b0, alu_bus.alu_a} - {1'b0, alu_bus.alu_b} - {8'd0, m_bin};
        m_r = m_s[7:0];
        m_c = ~m_s[8];
        m_v = (alu_bus.alu_a[7] != alu_bus.alu_b[7]) && (m_r[7] != alu_bus.alu_a[7]);
      end
      4'h6:    m_r = alu_bus.alu_b;
      4'hd:    m_r = alu_bus.alu_a;
      default: m_r = 8'd0;
    endcase
    alu_bus.alu_out = m_r;
    alu_bus.alu_c   = m_c;
    alu_bus.alu_z   = (m_r == 8'd0);
    alu_bus.alu_n   = m_r[7];
    alu_bus.alu_v   = m_v;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference from the D-register instruction semantics.
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] cc, output logic [15:0] er, output logic [3:0] ecc,
                       output logic ewr, output logic eill, output int elat);
    logic [16:0] s;
    logic [15:0] r;
    er = exp_result; ecc = cc; ewr = 1'b0; eill = 1'b0; elat = 1;
    case (op)
      3'd0: begin
        r = b; er = r; ewr = 1'b1; elat = 3;
        ecc = {r[15], r == 16'd0, 1'b0, cc[0]};
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0]; er = r; ewr = 1'b1; elat = 3;
        ecc = {r[15], r == 16'd0, (a[15] == b[15]) && (r[15] != a[15]), s[16]};
      end
      3'd2, 3'd3: begin
        r = a - b; elat = 3;
        if (op == 3'd2) begin er = r; ewr = 1'b1; end
        ecc = {r[15], r == 16'd0, (a[15] != b[15]) && (r[15] != a[15]), a < b};
      end
`ifdef ALU16_SEQ_MUL_EN
      3'd4: begin
        r = 16'(a[15:8]) * 16'(b[7:0]); er = r; ewr = 1'b1; elat = 10;
        ecc = {cc[3], r == 16'd0, cc[1], r[7]};
      end
`endif
      default: eill = 1'b1;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] cc, input bit hold);
    logic [15:0] er;
    logic [3:0]  ecc;
    logic        ewr, eill, swr, sill;
    int          elat, cyc, dones;
    model(op, a, b, cc, er, ecc, ewr, eill, elat);
    @(negedge clock);
    start = 1'b1; op16 = op; opnd_a = a; opnd_b = b; cc_in = cc;
    @(posedge clock); #1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    if (!hold) start = 1'b0;
    op16 = 3'($urandom); opnd_a = 16'($urandom); opnd_b = 16'($urandom); cc_in = 4'($urandom);
    cyc = 0; dones = 0; swr = 1'b0; sill = 1'b0;
    while (cyc < 20 && dones == 0) begin
      @(posedge clock); #1;
      cyc++;
      if (done) begin
        dones++; swr = wr_en; sill = illegal;
      end
    end
    start = 1'b0;
    chk("done_seen", dones, 32'd1);
    chk("latency", cyc, elat);
    chk("wr_en", {31'd0, swr}, {31'd0, ewr});
    chk("illegal", {31'd0, sill}, {31'd0, eill});
    chk("result_q", {16'd0, result_q}, {16'd0, er});
    chk("cc_out", {28'd0, cc_out}, {28'd0, ecc});
    exp_result = er;
    if (hold) begin
      repeat (3) begin
        @(posedge clock); #1;
        if (done) dones++;
      end
      chk("held_start_one_done", dones, 32'd1);
      chk("held_start_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  logic [15:0] edge_vals [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

  initial begin
    int seen;
    logic [15:0] ra, rb;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_result", {16'd0, result_q}, 32'd0);
    chk("rst_cc", {28'd0, cc_out}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_bus.alu_op}, 32'hd);
    chk("rst_alu_ab", {16'd0, alu_bus.alu_a, alu_bus.alu_b}, 32'd0);
    chk("rst_alu_op7_cin", {30'd0, alu_bus.alu_op7, alu_bus.alu_c_in}, 32'd0);
    reset_n = 1'b1;

    run_op(3'd1, 16'h12FF, 16'h0001, 4'h0, 1'b0);
    chk("t1_result", {16'd0, result_q}, 32'h1300);
    chk("t1_cc", {28'd0, cc_out}, 32'h0);
    run_op(3'd1, 16'hFFFF, 16'h0001, 4'h0, 1'b0);
    chk("t2_add_wrap_cc", {28'd0, cc_out}, 32'h5);
    run_op(3'd2, 16'h0000, 16'h0001, 4'h0, 1'b0);
    chk("t2_sub_neg", {16'd0, result_q}, 32'hFFFF);
    run_op(3'd2, 16'h0100, 16'h0001, 4'hF, 1'b0);
    chk("t2_sub_noborrow", {16'd0, result_q}, 32'h00FF);
    run_op(3'd0, 16'hABCD, 16'h1234, 4'hF, 1'b0);
    run_op(3'd3, 16'h8000, 16'h8000, 4'h0, 1'b0);
    chk("t3_cmpd_hold", {16'd0, result_q}, 32'h1234);
    chk("t3_cmpd_cc", {28'd0, cc_out}, 32'h4);
    run_op(3'd4, 16'hFF00, 16'h00FF, 4'hA, 1'b0);
    run_op(3'd4, 16'h0000, 16'h00FF, 4'h5, 1'b0);
    run_op(3'd1, 16'h0F0F, 16'h00F1, 4'h0, 1'b1);
    run_op(3'd6, 16'h1111, 16'h2222, 4'h9, 1'b0);
    chk("t5_illegal_cc", {28'd0, cc_out}, 32'h9);

    // Abort from the HI state with an asynchronous reset.
    @(negedge clock);
    start = 1'b1; op16 = 3'd1; opnd_a = 16'h4321; opnd_b = 16'h1111;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", {16'd0, result_q}, 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 32'd0);
    exp_result = 16'h0000;
    run_op(3'd1, 16'h1234, 16'h4321, 4'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      run_op(3'($urandom_range(0, 7)), ra, rb, 4'($urandom), bit'($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
